// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - shared encodings for the data memory slave and its register window
package data_mem_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10,
    MEM_RSVD  = 2'b11
  } mem_ctrl_e;

  localparam logic [1:0] OFS_CYCLE = 2'd0;
  localparam logic [1:0] OFS_GPIO  = 2'd1;
  localparam logic [1:0] OFS_STORE = 2'd2;
  localparam logic [1:0] OFS_ERR   = 2'd3;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_RANGE    = 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/data_mem_mmio.sv
// rtl/data_mem_mmio.sv - cycle/store counters, gpio and sticky error status behind the register window
module data_mem_mmio
  import data_mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  sel,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        store_done,
  input  logic        set_misalign,
  input  logic        set_range,
  output logic [31:0] rdata,
  output logic [31:0] gpio_out,
  output logic        err_flag
);

  logic [31:0] cycle_cnt;
  logic [31:0] store_cnt;
  logic [31:0] gpio_q;
  logic [1:0]  err_q;
  logic [1:0]  err_set;
  logic [1:0]  err_clr;
  logic [1:0]  err_next;

  // Set is applied after clear so a coincident set always survives.
  always_comb begin
    err_set               = '0;
    err_set[ERR_MISALIGN] = set_misalign;
    err_set[ERR_RANGE]    = set_range;
    err_clr               = (we && sel == OFS_ERR) ? wdata[1:0] : 2'b00;
    err_next              = (err_q & ~err_clr) | err_set;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      store_cnt <= '0;
      gpio_q    <= '0;
      err_q     <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      err_q     <= err_next;
      if (store_done) begin
        store_cnt <= sat_inc(store_cnt);
      end
      if (we && sel == OFS_GPIO) begin
        gpio_q <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      OFS_CYCLE: rdata = cycle_cnt;
      OFS_GPIO:  rdata = gpio_q;
      OFS_STORE: rdata = store_cnt;
      OFS_ERR:   rdata = {30'd0, err_q};
      default:   rdata = '0;
    endcase
  end

  assign gpio_out = gpio_q;
  assign err_flag = |err_q;

endmodule

// File: rtl/data_mem.sv
// rtl/data_mem.sv - MEM-stage data memory: word RAM plus a 4-register MMIO window, zero-latency reads
module data_mem
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_ctrl_input,
  input  logic [31:0] address,
  input  logic [31:0] w_data,
  output logic [31:0] read_data,
  output logic [31:0] gpio_out,
  output logic        err_flag
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]      ram [DEPTH_WORDS];
  mem_ctrl_e        ctrl;
  logic             is_read;
  logic             is_write;
  logic             misaligned;
  logic             ram_hit;
  logic             mmio_hit;
  logic [31:0]      mmio_ofs;
  logic [IDX_W-1:0] ram_idx;
  logic             ram_we;
  logic             mmio_we;
  logic             set_misalign;
  logic             set_range;
  logic [31:0]      mmio_rdata;

  assign ctrl = mem_ctrl_e'(mem_ctrl_input);

  // Reserved encoding behaves exactly like idle.
  always_comb begin
    is_read  = 1'b0;
    is_write = 1'b0;
    case (ctrl)
      MEM_READ:            is_read  = 1'b1;
      MEM_WRITE:           is_write = 1'b1;
      MEM_IDLE, MEM_RSVD:  ;
    endcase
  end

  assign misaligned = (address[1:0] != 2'b00);
  assign mmio_ofs   = address - MMIO_BASE;
  assign ram_hit    = (address < RAM_BYTES);
  assign mmio_hit   = !ram_hit && (mmio_ofs < 32'd16);
  assign ram_idx    = address[IDX_W+1:2];

  // Faulting accesses never touch state other than the error bits.
  assign set_misalign = (is_read || is_write) && misaligned;
  assign set_range    = (is_read || is_write) && !misaligned && !ram_hit && !mmio_hit;
  assign ram_we       = is_write && !misaligned && ram_hit;
  assign mmio_we      = is_write && !misaligned && mmio_hit;

  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      ram[ram_idx] <= w_data;
    end
  end

  data_mem_mmio u_mmio (
    .clk          (clk),
    .reset        (reset),
    .sel          (mmio_ofs[3:2]),
    .we           (mmio_we),
    .wdata        (w_data),
    .store_done   (ram_we),
    .set_misalign (set_misalign),
    .set_range    (set_range),
    .rdata        (mmio_rdata),
    .gpio_out     (gpio_out),
    .err_flag     (err_flag)
  );

  always_comb begin
    read_data = '0;
    if (is_read && !misaligned) begin
      if (ram_hit) begin
        read_data = ram[ram_idx];
      end else if (mmio_hit) begin
        read_data = mmio_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// tb/tb_data_mem.sv - randomized and directed self-checking bench for data_mem
module tb_data_mem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam logic [1:0]  C_IDLE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_RSV = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_ctrl_input;
  logic [31:0] address;
  logic [31:0] w_data;
  logic [31:0] read_data;
  logic [31:0] gpio_out;
  logic        err_flag;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mem [int];
  logic [31:0] m_cyc;
  logic [31:0] m_gpio;
  logic [31:0] m_store;
  logic [1:0]  m_err;

  data_mem #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_ctrl_input (mem_ctrl_input),
    .address        (address),
    .w_data         (w_data),
    .read_data      (read_data),
    .gpio_out       (gpio_out),
    .err_flag       (err_flag)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cyc   = 0;
    m_gpio  = 0;
    m_store = 0;
    m_err   = 0;
  endtask

  task automatic model_read(input logic [1:0] c, input logic [31:0] a,
                            output logic [31:0] v, output bit known);
    logic [31:0] off;
    known = 1'b1;
    v     = 32'd0;
    off   = a - BASE;
    if (c == C_RD && a[1:0] == 2'b00) begin
      if (a < 32'(DEPTH * 4)) begin
        if (m_mem.exists(int'(a >> 2))) v = m_mem[int'(a >> 2)];
        else known = 1'b0;
      end else if (a >= BASE && a <= BASE + 32'd15) begin
        case (off[3:2])
          2'd0: v = m_cyc;
          2'd1: v = m_gpio;
          2'd2: v = m_store;
          default: v = {30'd0, m_err};
        endcase
      end
    end
  endtask

  task automatic model_step(input logic [1:0] c, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] off;
    off   = a - BASE;
    m_cyc = m_cyc + 1;
    if (c == C_RD || c == C_WR) begin
      if (a[1:0] != 2'b00) begin
        m_err[0] = 1'b1;
      end else if (a < 32'(DEPTH * 4)) begin
        if (c == C_WR) begin
          m_mem[int'(a >> 2)] = wd;
          if (m_store != 32'hFFFF_FFFF) m_store = m_store + 1;
        end
      end else if (a >= BASE && a <= BASE + 32'd15) begin
        if (c == C_WR && off[3:2] == 2'd1) m_gpio = wd;
        if (c == C_WR && off[3:2] == 2'd3) m_err = m_err & ~wd[1:0];
      end else begin
        m_err[1] = 1'b1;
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic do_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
    logic [31:0] exp;
    bit          known;
    mem_ctrl_input = c;
    address        = a;
    w_data         = wd;
    #1;
    model_read(c, a, exp, known);
    rd = read_data;
    if (known) begin
      checks++;
      if (read_data !== exp) begin
        errors++;
        $display("FAIL read_data ctrl=%0d addr=%h got %h expected %h", c, a, read_data, exp);
      end
    end
    @(posedge clk);
    model_step(c, a, wd);
    #1;
    checks++;
    if (gpio_out !== m_gpio) begin
      errors++;
      $display("FAIL gpio_out got %h expected %h", gpio_out, m_gpio);
    end
    checks++;
    if (err_flag !== (|m_err)) begin
      errors++;
      $display("FAIL err_flag got %b expected %b", err_flag, |m_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] a, b;
    reset = 1'b1;
    mem_ctrl_input = C_IDLE;
    address = 0;
    w_data = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (gpio_out !== 32'd0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got gpio=%h err=%b expected 0/0", gpio_out, err_flag);
    end
    mem_ctrl_input = C_RD;
    address = BASE;
    #1;
    checks++;
    if (read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_cycle got %h expected 0", read_data);
    end
    reset = 1'b0;
    model_reset();
    do_op(C_RD, BASE, 0, a);
    do_op(C_RD, BASE, 0, b);
    checks++;
    if (b !== a + 32'd1) begin
      errors++;
      $display("FAIL cycle_step got %h then %h expected difference 1", a, b);
    end
  endtask

  task automatic test_ram_basic();
    logic [31:0] rd;
    do_op(C_WR, 32'h10, 32'hDEAD_BEEF, rd);
    do_op(C_IDLE, 32'h10, 0, rd);
    do_op(C_RD, 32'h10, 0, rd);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL ram_readback got %h expected deadbeef", rd);
    end
    do_op(C_RD, BASE + 32'd8, 0, rd);
    checks++;
    if (rd !== 32'd1) begin
      errors++;
      $display("FAIL store_cnt got %h expected 1", rd);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    do_op(C_WR, 32'h13, 32'h1111_1111, rd);
    do_op(C_RD, 32'h10, 0, rd);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL misalign_suppress got %h expected deadbeef", rd);
    end
    do_op(C_RD, BASE + 32'd12, 0, rd);
    checks++;
    if (rd !== 32'd1 || err_flag !== 1'b1) begin
      errors++;
      $display("FAIL misalign_status got %h/%b expected 1/1", rd, err_flag);
    end
    do_op(C_WR, BASE + 32'd12, 32'd1, rd);
    do_op(C_RD, BASE + 32'd12, 0, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL w1c_clear got %h expected 0", rd);
    end
  endtask

  task automatic test_range();
    logic [31:0] rd;
    do_op(C_RD, 32'(DEPTH * 4), 0, rd);
    checks++;
    if (rd !== 32'd0) begin
      errors++;
      $display("FAIL range_read got %h expected 0", rd);
    end
    do_op(C_RD, BASE + 32'd12, 0, rd);
    checks++;
    if (rd !== 32'd2) begin
      errors++;
      $display("FAIL range_status got %h expected 2", rd);
    end
    // A misaligned clear attempt of bit0: the fault sets bit0, the clear is dropped.
    do_op(C_WR, BASE + 32'd13, 32'd1, rd);
    do_op(C_RD, BASE + 32'd12, 0, rd);
    checks++;
    if (rd !== 32'd3) begin
      errors++;
      $display("FAIL set_wins got %h expected 3", rd);
    end
    do_op(C_WR, BASE + 32'd12, 32'd3, rd);
  endtask

  task automatic test_gpio();
    logic [31:0] rd, c1, c2;
    do_op(C_WR, BASE + 32'd4, 32'h0000_00A5, rd);
    checks++;
    if (gpio_out !== 32'hA5) begin
      errors++;
      $display("FAIL gpio_load got %h expected a5", gpio_out);
    end
    do_op(C_RD, BASE, 0, c1);
    do_op(C_WR, BASE, 32'd0, rd);
    do_op(C_RD, BASE, 0, c2);
    checks++;
    if (c2 !== c1 + 32'd2 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL cycle_ro got %h->%h err=%b expected +2 err=0", c1, c2, err_flag);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, a;
    logic [1:0]  c;
    for (int i = 0; i < 400; i++) begin
      c = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 6))
        0, 1: a = 32'($urandom_range(0, 15)) << 2;
        2:    a = 32'((DEPTH - 1) * 4);
        3:    a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        4:    a = 32'(DEPTH * 4) + (32'($urandom_range(0, 1000)) << 2);
        5:    a = BASE + (32'($urandom_range(0, 3)) << 2);
        default: a = BASE + 32'd16 + (32'($urandom_range(0, 3)) << 2);
      endcase
      do_op(c, a, $urandom, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    do_op(C_WR, 32'h20, 32'h1234_5678, rd);
    do_op(C_WR, BASE + 32'd4, 32'h5A5A_0001, rd);
    do_op(C_RD, 32'h3, 0, rd);
    mem_ctrl_input = C_WR;
    address = 32'h20;
    w_data = 32'hCAFE_F00D;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (gpio_out !== 32'd0 || err_flag !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got gpio=%h err=%b expected 0/0", gpio_out, err_flag);
    end
    @(posedge clk);
    @(negedge clk);
    mem_ctrl_input = C_RD;
    address = BASE + 32'd8;
    #1;
    checks++;
    if (read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_store got %h expected 0", read_data);
    end
    reset = 1'b0;
    model_reset();
    do_op(C_RD, 32'h20, 0, rd);
    checks++;
    if (rd !== 32'h1234_5678) begin
      errors++;
      $display("FAIL reset_drops_write got %h expected 12345678", rd);
    end
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_misalign();
    test_range();
    test_gpio();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
